// File: rtl/rvh_l1d_mshr_alloc_tracker_if.sv
// Miss-pipe <-> MSHR allocation tracker bundle.
// Carries the allocation, deallocation, flush and status signals.
interface rvh_l1d_mshr_alloc_tracker_if #(
   parameter int MSHR_NUM       = 8,
   parameter int ALLOC_PORT_NUM = 2,
   parameter int MSHR_ID_W      = $clog2(MSHR_NUM)
);
   logic [ALLOC_PORT_NUM-1:0]           alloc_req_i;
   logic [ALLOC_PORT_NUM-1:0]           alloc_prio_i;
   logic [ALLOC_PORT_NUM-1:0]           alloc_gnt_o;
   logic [ALLOC_PORT_NUM*MSHR_ID_W-1:0] alloc_id_o;
   logic                                dealloc_vld_i;
   logic [MSHR_NUM-1:0]                 dealloc_mask_i;
   logic                                flush_i;
   logic [MSHR_NUM-1:0]                 mshr_valid_o;
   logic [MSHR_ID_W:0]                  free_cnt_o;
   logic                                full_o;
   logic                                empty_o;
   logic                                dealloc_err_o;

   modport master (
      output alloc_req_i,
      output alloc_prio_i,
      output dealloc_vld_i,
      output dealloc_mask_i,
      output flush_i,
      input  alloc_gnt_o,
      input  alloc_id_o,
      input  mshr_valid_o,
      input  free_cnt_o,
      input  full_o,
      input  empty_o,
      input  dealloc_err_o
   );

   modport slave (
      input  alloc_req_i,
      input  alloc_prio_i,
      input  dealloc_vld_i,
      input  dealloc_mask_i,
      input  flush_i,
      output alloc_gnt_o,
      output alloc_id_o,
      output mshr_valid_o,
      output free_cnt_o,
      output full_o,
      output empty_o,
      output dealloc_err_o
   );
endinterface

// File: rtl/rvh_l1d_mshr_alloc_tracker.sv
// L1D MSHR allocation tracker: owns the valid vector, grants lowest
// free IDs in port order, keeps entries back for priority requests.
module rvh_l1d_mshr_alloc_tracker #(
   parameter int MSHR_NUM       = 8,
   parameter int ALLOC_PORT_NUM = 2,
   parameter int RESERVE_NUM    = 1,
   parameter int MSHR_ID_W      = $clog2(MSHR_NUM)
) (
   input  logic                       clk,
   input  logic                       rst,
   rvh_l1d_mshr_alloc_tracker_if.slave bus
);
   localparam int               CNT_W = MSHR_ID_W + 1;
   localparam logic [CNT_W-1:0] RSV   = CNT_W'(RESERVE_NUM);
   localparam logic [CNT_W-1:0] FULLC = CNT_W'(MSHR_NUM);

   logic [MSHR_NUM-1:0]                 r_valid;
   logic [CNT_W-1:0]                    r_free_cnt;
   logic                                r_full;
   logic                                r_empty;
   logic                                r_err;

   logic [MSHR_NUM-1:0]                 w_taken;
   logic [MSHR_NUM-1:0]                 w_alloc_mask;
   logic [MSHR_NUM-1:0]                 w_dealloc_eff;
   logic [MSHR_NUM-1:0]                 w_valid_nxt;
   logic [CNT_W-1:0]                    w_avail;
   logic [CNT_W-1:0]                    w_free_nxt;
   logic                                w_err_nxt;
   logic                                w_found;
   logic                                w_ok;
   logic [MSHR_ID_W-1:0]                w_sel;
   logic [ALLOC_PORT_NUM-1:0]           w_gnt;
   logic [ALLOC_PORT_NUM*MSHR_ID_W-1:0] w_id;

   function automatic logic [CNT_W-1:0] f_zeros(
      input logic [MSHR_NUM-1:0] v
   );
      logic [CNT_W-1:0] c;
      c = '0;
      for (int i = 0; i < MSHR_NUM; i++) begin
         c = c + CNT_W'(!v[i]);
      end
      return c;
   endfunction

   // Each port sees what lower ports left behind; denied ports take nothing.
   always_comb begin
      w_gnt        = '0;
      w_id         = '0;
      w_alloc_mask = '0;
      w_taken      = r_valid;
      w_avail      = r_free_cnt;
      w_found      = 1'b0;
      w_ok         = 1'b0;
      w_sel        = '0;
      for (int p = 0; p < ALLOC_PORT_NUM; p++) begin
         w_found = 1'b0;
         w_sel   = '0;
         for (int i = 0; i < MSHR_NUM; i++) begin
            if (!w_found && !w_taken[i]) begin
               w_found = 1'b1;
               w_sel   = MSHR_ID_W'(i);
            end
         end
         w_ok = bus.alloc_prio_i[p] ? (w_avail != '0)
                                    : (w_avail > RSV);
         if (rst && !bus.flush_i && bus.alloc_req_i[p]
             && w_found && w_ok) begin
            w_gnt[p]                         = 1'b1;
            w_id[p*MSHR_ID_W +: MSHR_ID_W]   = w_sel;
            w_taken[w_sel]                   = 1'b1;
            w_alloc_mask[w_sel]              = 1'b1;
            w_avail                          = w_avail - CNT_W'(1);
         end
      end
   end

   assign w_dealloc_eff = bus.dealloc_vld_i
                        ? (bus.dealloc_mask_i & r_valid)
                        : '0;

   // A flush supersedes any stray dealloc, so no error is reported.
   assign w_err_nxt = bus.dealloc_vld_i & ~bus.flush_i
                    & (|(bus.dealloc_mask_i & ~r_valid));

   assign w_valid_nxt = bus.flush_i
                      ? '0
                      : ((r_valid & ~w_dealloc_eff) | w_alloc_mask);

   assign w_free_nxt = f_zeros(w_valid_nxt);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= '0;
         r_free_cnt <= FULLC;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_err      <= 1'b0;
      end else begin
         r_valid    <= w_valid_nxt;
         r_free_cnt <= w_free_nxt;
         r_full     <= (w_free_nxt == '0);
         r_empty    <= (w_free_nxt == FULLC);
         r_err      <= w_err_nxt;
      end
   end

   assign bus.alloc_gnt_o   = w_gnt;
   assign bus.alloc_id_o    = w_id;
   assign bus.mshr_valid_o  = r_valid;
   assign bus.free_cnt_o    = r_free_cnt;
   assign bus.full_o        = r_full;
   assign bus.empty_o       = r_empty;
   assign bus.dealloc_err_o = r_err;
endmodule

// File: tb/tb_rvh_l1d_mshr_alloc_tracker.sv
// Bench for rvh_l1d_mshr_alloc_tracker: directed scenarios plus a
// randomized run against a free-list reference model.
module tb_rvh_l1d_mshr_alloc_tracker;
   localparam int N  = 8;
   localparam int P  = 2;
   localparam int R  = 1;
   localparam int IW = 3;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rvh_l1d_mshr_alloc_tracker_if #(
      .MSHR_NUM(N), .ALLOC_PORT_NUM(P), .MSHR_ID_W(IW)
   ) bus ();

   rvh_l1d_mshr_alloc_tracker #(
      .MSHR_NUM(N), .ALLOC_PORT_NUM(P),
      .RESERVE_NUM(R), .MSHR_ID_W(IW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic [1:0] req, input logic [1:0] prio,
                        input logic dv, input logic [7:0] mask,
                        input logic fl);
      bus.alloc_req_i    = req;
      bus.alloc_prio_i   = prio;
      bus.dealloc_vld_i  = dv;
      bus.dealloc_mask_i = mask;
      bus.flush_i        = fl;
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Flush, fill every entry with priority allocs, then free ~v.
   task automatic set_state(input logic [7:0] v);
      drive(2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
      tick();
      for (int k = 0; k < N / P; k++) begin
         drive(2'b11, 2'b11, 1'b0, 8'h00, 1'b0);
         tick();
      end
      if (v != 8'hFF) begin
         drive(2'b00, 2'b00, 1'b1, ~v, 1'b0);
         tick();
      end
      idle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      #2 rst = 1'b0;
      drive(2'b11, 2'b11, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if (bus.mshr_valid_o !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_valid: got %h want 00", bus.mshr_valid_o);
      end
      n_tests++;
      if ({bus.free_cnt_o, bus.full_o, bus.empty_o, bus.dealloc_err_o}
          !== {4'd8, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_status: got cnt=%0d full=%b empty=%b err=%b want 8/0/1/0",
                  bus.free_cnt_o, bus.full_o, bus.empty_o, bus.dealloc_err_o);
      end
      n_tests++;
      if (bus.alloc_gnt_o !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_gnt: got %b want 00", bus.alloc_gnt_o);
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      idle();
      rst = 1'b1;
   endtask

   task automatic test_basic();
      drive(2'b11, 2'b00, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.alloc_id_o} !== {2'b11, 3'd1, 3'd0}) begin
         n_fail++;
         $display("FAIL basic_gnt: got gnt=%b id=%h want gnt=11 id=08",
                  bus.alloc_gnt_o, bus.alloc_id_o);
      end
      tick();
      idle();
      n_tests++;
      if ({bus.mshr_valid_o, bus.free_cnt_o} !== {8'h03, 4'd6}) begin
         n_fail++;
         $display("FAIL basic_state: got valid=%h cnt=%0d want 03/6",
                  bus.mshr_valid_o, bus.free_cnt_o);
      end
   endtask

   task automatic test_reserve();
      set_state(8'h7E);
      drive(2'b11, 2'b10, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.alloc_id_o} !== {2'b11, 3'd7, 3'd0}) begin
         n_fail++;
         $display("FAIL reserve_gnt: got gnt=%b id=%h want gnt=11 id=38",
                  bus.alloc_gnt_o, bus.alloc_id_o);
      end
      tick();
      idle();
      n_tests++;
      if ({bus.mshr_valid_o, bus.free_cnt_o, bus.full_o, bus.empty_o}
          !== {8'hFF, 4'd0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reserve_full: got valid=%h cnt=%0d full=%b want FF/0/1",
                  bus.mshr_valid_o, bus.free_cnt_o, bus.full_o);
      end
   endtask

   task automatic test_denial();
      set_state(8'hFE);
      drive(2'b01, 2'b00, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.alloc_id_o} !== 8'h00) begin
         n_fail++;
         $display("FAIL deny_gnt: got gnt=%b id=%h want 0/0",
                  bus.alloc_gnt_o, bus.alloc_id_o);
      end
      tick();
      n_tests++;
      if ({bus.mshr_valid_o, bus.free_cnt_o} !== {8'hFE, 4'd1}) begin
         n_fail++;
         $display("FAIL deny_state: got valid=%h cnt=%0d want FE/1",
                  bus.mshr_valid_o, bus.free_cnt_o);
      end
      drive(2'b01, 2'b01, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.alloc_id_o} !== {2'b01, 6'd0}) begin
         n_fail++;
         $display("FAIL deny_prio: got gnt=%b id=%h want 01/00",
                  bus.alloc_gnt_o, bus.alloc_id_o);
      end
      tick();
      idle();
   endtask

   task automatic test_back_to_back();
      set_state(8'hFF);
      drive(2'b11, 2'b11, 1'b1, 8'h81, 1'b0);
      #1;
      n_tests++;
      if (bus.alloc_gnt_o !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_nobypass: got %b want 00", bus.alloc_gnt_o);
      end
      tick();
      idle();
      n_tests++;
      if ({bus.mshr_valid_o, bus.free_cnt_o, bus.dealloc_err_o}
          !== {8'h7E, 4'd2, 1'b0}) begin
         n_fail++;
         $display("FAIL b2b_state: got valid=%h cnt=%0d err=%b want 7E/2/0",
                  bus.mshr_valid_o, bus.free_cnt_o, bus.dealloc_err_o);
      end
      drive(2'b11, 2'b11, 1'b0, 8'h00, 1'b0);
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.alloc_id_o} !== {2'b11, 3'd7, 3'd0}) begin
         n_fail++;
         $display("FAIL b2b_gnt: got gnt=%b id=%h want 11/38",
                  bus.alloc_gnt_o, bus.alloc_id_o);
      end
      tick();
      idle();
   endtask

   task automatic test_err_flush();
      set_state(8'h0F);
      drive(2'b00, 2'b00, 1'b1, 8'h30, 1'b0);
      tick();
      idle();
      n_tests++;
      if ({bus.mshr_valid_o, bus.dealloc_err_o} !== {8'h0F, 1'b1}) begin
         n_fail++;
         $display("FAIL err_pulse: got valid=%h err=%b want 0F/1",
                  bus.mshr_valid_o, bus.dealloc_err_o);
      end
      tick();
      n_tests++;
      if (bus.dealloc_err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_width: got %b want 0", bus.dealloc_err_o);
      end
      drive(2'b11, 2'b11, 1'b1, 8'hF0, 1'b1);
      #1;
      n_tests++;
      if (bus.alloc_gnt_o !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_gnt: got %b want 00", bus.alloc_gnt_o);
      end
      tick();
      idle();
      n_tests++;
      if ({bus.mshr_valid_o, bus.free_cnt_o, bus.empty_o, bus.dealloc_err_o}
          !== {8'h00, 4'd8, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_state: got valid=%h cnt=%0d empty=%b err=%b want 00/8/1/0",
                  bus.mshr_valid_o, bus.free_cnt_o, bus.empty_o, bus.dealloc_err_o);
      end
   endtask

   task automatic test_mid_reset();
      set_state(8'h3C);
      drive(2'b11, 2'b11, 1'b0, 8'h00, 1'b0);
      #1 rst = 1'b0;
      #1;
      n_tests++;
      if ({bus.alloc_gnt_o, bus.mshr_valid_o, bus.free_cnt_o}
          !== {2'b00, 8'h00, 4'd8}) begin
         n_fail++;
         $display("FAIL midrst: got gnt=%b valid=%h cnt=%0d want 00/00/8",
                  bus.alloc_gnt_o, bus.mshr_valid_o, bus.free_cnt_o);
      end
      tick();
      idle();
      rst = 1'b1;
   endtask

   task automatic test_random();
      logic [7:0] m_valid;
      logic [7:0] amask;
      logic [7:0] mask;
      logic [1:0] req;
      logic [1:0] prio;
      logic [1:0] e_gnt;
      logic [5:0] e_id;
      logic       dv;
      logic       fl;
      logic       e_err;
      int         freeq[$];
      int         used;
      int         avail;
      int         cnt;
      drive(2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
      tick();
      idle();
      m_valid = 8'h00;
      for (int c = 0; c < 400; c++) begin
         req  = 2'($urandom);
         prio = 2'($urandom);
         dv   = ($urandom_range(0, 3) == 0);
         mask = 8'($urandom);
         fl   = ($urandom_range(0, 39) == 0);
         drive(req, prio, dv, mask, fl);
         #1;
         freeq.delete();
         for (int i = 0; i < N; i++)
            if (!m_valid[i]) freeq.push_back(i);
         used  = 0;
         e_gnt = '0;
         e_id  = '0;
         amask = '0;
         for (int p = 0; p < P; p++) begin
            avail = freeq.size() - used;
            if (req[p] && !fl && (prio[p] ? avail > 0 : avail > R)) begin
               e_gnt[p]          = 1'b1;
               e_id[p*IW +: IW]  = 3'(freeq[used]);
               amask[freeq[used]] = 1'b1;
               used++;
            end
         end
         n_tests++;
         if ({bus.alloc_gnt_o, bus.alloc_id_o} !== {e_gnt, e_id}) begin
            n_fail++;
            $display("FAIL rnd_gnt[%0d]: got gnt=%b id=%h want gnt=%b id=%h",
                     c, bus.alloc_gnt_o, bus.alloc_id_o, e_gnt, e_id);
         end
         e_err = dv && !fl && ((mask & ~m_valid) != 0);
         if (fl) m_valid = 8'h00;
         else if (dv) m_valid = (m_valid & ~mask) | amask;
         else m_valid = m_valid | amask;
         cnt = N - $countones(m_valid);
         tick();
         n_tests++;
         if ({bus.mshr_valid_o, bus.free_cnt_o, bus.full_o,
              bus.empty_o, bus.dealloc_err_o}
             !== {m_valid, 4'(cnt), cnt == 0, cnt == N, e_err}) begin
            n_fail++;
            $display("FAIL rnd_state[%0d]: got v=%h cnt=%0d f=%b e=%b err=%b want v=%h cnt=%0d err=%b",
                     c, bus.mshr_valid_o, bus.free_cnt_o, bus.full_o,
                     bus.empty_o, bus.dealloc_err_o, m_valid, cnt, e_err);
         end
      end
      idle();
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_basic();
      test_reserve();
      test_denial();
      test_back_to_back();
      test_err_flush();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
